// File: rtl/ac_climate_sim_if.sv
// ac_climate_sim_if: user/display-side bundle of the climate simulator.
//   master (user/set-temp logic + recharge logic) drives:
//     on_off, mode_in[1:0], set_temp[TW], power_in[PW], load_power
//   slave (ac_climate_sim) drives:
//     mode[1:0], env_temp[TW], power[PW], tick, power_empty, at_target
interface ac_climate_sim_if #(
  parameter int TW = 9,
  parameter int PW = 10
);
  logic          on_off;
  logic [1:0]    mode_in;
  logic [TW-1:0] set_temp;
  logic [PW-1:0] power_in;
  logic          load_power;
  logic [1:0]    mode;
  logic [TW-1:0] env_temp;
  logic [PW-1:0] power;
  logic          tick;
  logic          power_empty;
  logic          at_target;

  modport master (
    output on_off, mode_in, set_temp, power_in, load_power,
    input  mode, env_temp, power, tick, power_empty, at_target
  );

  modport slave (
    input  on_off, mode_in, set_temp, power_in, load_power,
    output mode, env_temp, power, tick, power_empty, at_target
  );
endinterface

// File: rtl/ac_climate_sim.sv
// ac_climate_sim: air-conditioner mode / room-temperature / power simulator.
// Everything runs on clk; a prescaler produces a one-cycle tick enable and
// all mode/temperature/power updates happen on tick edges, except recharge.
// Ports:
//   clk  - system clock
//   rst  - asynchronous active-low reset
//   io   - ac_climate_sim_if.slave: user inputs (on_off, mode_in, set_temp,
//          power_in, load_power) and status outputs (mode, env_temp, power,
//          tick, power_empty, at_target)
// Temperatures are 0.1 degC/LSB, power is 0.1 W/LSB.
module ac_climate_sim #(
  parameter int CLK_DIV     = 10_000_000,
  parameter int TW          = 9,
  parameter int PW          = 10,
  parameter int ENV_INIT    = 240,
  parameter int POWER_INIT  = 100,
  parameter int AMBIENT     = 240,
  parameter int TEMP_MIN    = 160,
  parameter int TEMP_MAX    = 300,
  parameter int HYST        = 5,
  parameter int STEP_TICKS  = 10,
  parameter int WIND_TICKS  = 4,
  parameter int DRIFT_TICKS = 20,
  parameter int COST_ACTIVE = 1,
  parameter int COST_WIND   = 1
) (
  input  logic clk,
  input  logic rst,
  ac_climate_sim_if.slave io
);

  localparam int DW = (CLK_DIV     > 1) ? $clog2(CLK_DIV)     : 1;
  localparam int SW = (STEP_TICKS  > 1) ? $clog2(STEP_TICKS)  : 1;
  localparam int WW = (WIND_TICKS  > 1) ? $clog2(WIND_TICKS)  : 1;
  localparam int RW = (DRIFT_TICKS > 1) ? $clog2(DRIFT_TICKS) : 1;
  // Comparisons run one bit wider so set_temp+HYST cannot wrap.
  localparam int TX = TW + 1;

  typedef enum logic [1:0] {
    M_WIND = 2'b00,
    M_COLD = 2'b01,
    M_HOT  = 2'b10
  } mode_e;

  logic [DW-1:0] div_q, div_d;
  logic [SW-1:0] step_q, step_d;
  logic [WW-1:0] wind_q, wind_d;
  logic [RW-1:0] drift_q, drift_d;
  mode_e         mode_q, mode_d;
  logic [TW-1:0] env_q, env_d;
  logic [PW-1:0] power_q, power_d;
  logic          on_q, on_d;

  logic          tick;
  mode_e         nm;
  logic          act;
  logic          oo_clr;
  logic [TX-1:0] env_x, set_x;

  function automatic logic [TW-1:0] clamp_t(input logic [TX-1:0] v);
    if (v < TX'(TEMP_MIN)) return TW'(TEMP_MIN);
    if (v > TX'(TEMP_MAX)) return TW'(TEMP_MAX);
    return v[TW-1:0];
  endfunction

  function automatic logic [PW-1:0] sub_sat(input logic [PW-1:0] p,
                                            input logic [PW-1:0] c);
    return (p > c) ? p - c : '0;
  endfunction

  // One LSB toward AMBIENT; stays put once there.
  function automatic logic [TW-1:0] drift_t(input logic [TW-1:0] e);
    if (e < TW'(AMBIENT)) return e + 1'b1;
    if (e > TW'(AMBIENT)) return e - 1'b1;
    return e;
  endfunction

  assign tick = (div_q == DW'(CLK_DIV - 1));

  always_comb begin
    nm      = M_WIND;
    act     = io.on_off && (power_q != '0);
    oo_clr  = (io.on_off != on_q);
    env_x   = {1'b0, env_q};
    set_x   = {1'b0, io.set_temp};
    div_d   = tick ? '0 : div_q + 1'b1;
    on_d    = io.on_off;
    mode_d  = mode_q;
    env_d   = env_q;
    power_d = power_q;
    // An on/off transition restarts the activity counters but never the
    // prescaler, so tick phase is unaffected by the user.
    step_d  = oo_clr ? '0 : step_q;
    wind_d  = oo_clr ? '0 : wind_q;
    drift_d = oo_clr ? '0 : drift_q;

    if (tick) begin
      // Resolution looks at pre-update env_temp; the hold case gives the
      // hysteresis band between set_temp and set_temp+/-HYST.
      if (act) begin
        case (io.mode_in)
          2'b01: begin
            if (env_x > set_x + TX'(HYST))  nm = M_COLD;
            else if (env_x <= set_x)        nm = M_WIND;
            else nm = (mode_q == M_COLD) ? M_COLD : M_WIND;
          end
          2'b10: begin
            if (env_x + TX'(HYST) < set_x)  nm = M_HOT;
            else if (env_x >= set_x)        nm = M_WIND;
            else nm = (mode_q == M_HOT) ? M_HOT : M_WIND;
          end
          default: nm = M_WIND;
        endcase
      end
      mode_d = nm;

      // A mode change restarts the period counters, then this tick counts.
      if (nm != mode_q) begin
        step_d = '0;
        wind_d = '0;
      end

      if (act && nm != M_WIND) begin
        if (step_d == SW'(STEP_TICKS - 1)) begin
          step_d = '0;
          if (nm == M_COLD) env_d = clamp_t((env_x == '0) ? '0 : env_x - 1'b1);
          else              env_d = clamp_t(env_x + 1'b1);
        end else begin
          step_d = step_d + 1'b1;
        end
        power_d = sub_sat(power_q, PW'(COST_ACTIVE));
      end else begin
        // Wind (active) pays a periodic fan cost; wind and idle both drift.
        if (act) begin
          if (wind_d == WW'(WIND_TICKS - 1)) begin
            wind_d  = '0;
            power_d = sub_sat(power_q, PW'(COST_WIND));
          end else begin
            wind_d = wind_d + 1'b1;
          end
        end
        if (drift_d == RW'(DRIFT_TICKS - 1)) begin
          drift_d = '0;
          env_d   = drift_t(env_q);
        end else begin
          drift_d = drift_d + 1'b1;
        end
      end
    end

    // Recharge only while off; it overrides any tick-time power update.
    if (io.load_power && !io.on_off) power_d = io.power_in;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_q   <= '0;
      step_q  <= '0;
      wind_q  <= '0;
      drift_q <= '0;
      mode_q  <= M_WIND;
      env_q   <= TW'(ENV_INIT);
      power_q <= PW'(POWER_INIT);
      on_q    <= 1'b0;
    end else begin
      div_q   <= div_d;
      step_q  <= step_d;
      wind_q  <= wind_d;
      drift_q <= drift_d;
      mode_q  <= mode_d;
      env_q   <= env_d;
      power_q <= power_d;
      on_q    <= on_d;
    end
  end

  assign io.mode        = mode_q;
  assign io.env_temp    = env_q;
  assign io.power       = power_q;
  assign io.tick        = tick;
  assign io.power_empty = (power_q == '0);
  assign io.at_target   = (env_q == io.set_temp);

endmodule

// File: tb/tb_ac_climate_sim.sv
// Bench for ac_climate_sim (CLK_DIV=4). A tick-level reference model pushes
// the expected state after every tick edge into a queue; an independent
// monitor pops and compares whenever the DUT shows a tick. Directed phases
// follow the test plan, then randomized segments exercise the rest.
module tb_ac_climate_sim;
  localparam int CLK_DIV = 4;
  localparam int TMIN = 160, TMAX = 300, AMB = 240, HYST = 5;
  localparam int STEP = 10, WIND = 4, DRIFT = 20;

  logic clk;
  logic rst;
  ac_climate_sim_if #(.TW(9), .PW(10)) io();

  ac_climate_sim #(.CLK_DIV(CLK_DIV)) dut (
    .clk (clk),
    .rst (rst),
    .io  (io)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int mode;
    int env;
    int power;
  } exp_t;

  exp_t sbq[$];
  int n_checks = 0;
  int n_errors = 0;

  // stimulus variables
  int on, mi, st, pin, ld;

  // reference model state
  int m_cnt, m_mode, m_env, m_power, m_step, m_wind, m_drift, m_onp;

  function automatic void chk(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic int clampi(int v);
    if (v < TMIN) return TMIN;
    if (v > TMAX) return TMAX;
    return v;
  endfunction

  task automatic model_init();
    m_cnt = 0; m_mode = 0; m_env = 240; m_power = 100;
    m_step = 0; m_wind = 0; m_drift = 0; m_onp = 0;
  endtask

  // Effect of the coming clock edge, given the current inputs.
  task automatic model_edge();
    bit tk;
    int nm;
    bit act;
    exp_t e;
    tk = (m_cnt == CLK_DIV - 1);
    if (on != m_onp) begin m_step = 0; m_wind = 0; m_drift = 0; end
    if (tk) begin
      act = (on != 0) && (m_power != 0);
      nm = 0;
      if (act) begin
        if (mi == 1) begin
          if (m_env > st + HYST) nm = 1;
          else if (m_env <= st)  nm = 0;
          else                   nm = (m_mode == 1) ? 1 : 0;
        end else if (mi == 2) begin
          if (m_env + HYST < st) nm = 2;
          else if (m_env >= st)  nm = 0;
          else                   nm = (m_mode == 2) ? 2 : 0;
        end
      end
      if (nm != m_mode) begin m_step = 0; m_wind = 0; end
      if (act && nm != 0) begin
        m_step++;
        if (m_step == STEP) begin
          m_step = 0;
          m_env = clampi((nm == 1) ? m_env - 1 : m_env + 1);
        end
        m_power = (m_power > 1) ? m_power - 1 : 0;
      end else begin
        if (act) begin
          m_wind++;
          if (m_wind == WIND) begin
            m_wind = 0;
            m_power = (m_power > 1) ? m_power - 1 : 0;
          end
        end
        m_drift++;
        if (m_drift == DRIFT) begin
          m_drift = 0;
          if (m_env < AMB) m_env++;
          else if (m_env > AMB) m_env--;
        end
      end
      m_mode = nm;
    end
    if (ld != 0 && on == 0) m_power = pin;
    if (tk) begin
      e.mode = m_mode; e.env = m_env; e.power = m_power;
      sbq.push_back(e);
    end
    m_onp = on;
    m_cnt = tk ? 0 : m_cnt + 1;
  endtask

  // Called at a negedge: drive inputs, advance model, wait one cycle.
  task automatic run_cycle();
    io.on_off     = on[0];
    io.mode_in    = mi[1:0];
    io.set_temp   = st[8:0];
    io.power_in   = pin[9:0];
    io.load_power = ld[0];
    model_edge();
    @(negedge clk);
  endtask

  task automatic run_ticks(int k);
    int n = 0;
    while (n < k) begin
      if (m_cnt == CLK_DIV - 1) n++;
      run_cycle();
    end
  endtask

  task automatic run_until_env(int target, string name);
    int guard = 0;
    while (m_env != target && guard < 4000) begin
      run_ticks(1);
      guard++;
    end
    if (guard >= 4000) begin
      n_checks++; n_errors++;
      $display("FAIL %s: model env never reached %0d", name, target);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    rst = 1'b0;
    on = 0; mi = 0; st = 200; pin = 0; ld = 0;
    io.on_off = 1'b0; io.mode_in = 2'b00; io.set_temp = 9'd200;
    io.power_in = '0; io.load_power = 1'b0;
    model_init();
    sbq.delete();
    repeat (2) @(negedge clk);
    chk("rst_mode", int'(io.mode), 0);
    chk("rst_env", int'(io.env_temp), 240);
    chk("rst_power", int'(io.power), 100);
    chk("rst_tick", int'(io.tick), 0);
    chk("rst_empty", int'(io.power_empty), 0);
    rst = 1'b1;
  endtask

  // Scoreboard monitor.
  initial begin
    bit seen;
    exp_t e;
    forever begin
      @(negedge clk);
      seen = io.tick && rst;
      if (seen) begin
        @(posedge clk); #1;
        if (sbq.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL sb_unexpected_tick: DUT ticked with no expectation at %0t", $time);
        end else begin
          e = sbq.pop_front();
          chk("sb_mode", int'(io.mode), e.mode);
          chk("sb_env", int'(io.env_temp), e.env);
          chk("sb_power", int'(io.power), e.power);
          chk("sb_empty", int'(io.power_empty), (e.power == 0) ? 1 : 0);
          chk("sb_at_target", int'(io.at_target), (e.env == int'(io.set_temp)) ? 1 : 0);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    model_init();

    // Cold for 10 ticks.
    do_reset();
    on = 1; mi = 1; st = 220;
    run_ticks(10);
    chk("cold_mode", int'(io.mode), 1);
    chk("cold_env", int'(io.env_temp), 239);
    chk("cold_power", int'(io.power), 90);

    // Wind cost over 8 ticks at ambient.
    do_reset();
    on = 1; mi = 0; st = 200;
    run_ticks(8);
    chk("wind_power", int'(io.power), 98);
    chk("wind_env", int'(io.env_temp), 240);
    chk("wind_mode", int'(io.mode), 0);

    // Exhaustion, then a recharge attempt while on.
    do_reset();
    ld = 1; pin = 3; run_cycle(); ld = 0;
    on = 1; mi = 2; st = 280;
    run_ticks(3);
    chk("exh_power", int'(io.power), 0);
    chk("exh_empty", int'(io.power_empty), 1);
    run_ticks(1);
    chk("exh_mode", int'(io.mode), 0);
    ld = 1; pin = 50; run_cycle(); ld = 0;
    chk("exh_load_on", int'(io.power), 0);

    // Recharge coincident with a tick, then hot into the upper clamp.
    on = 0;
    while (m_cnt != CLK_DIV - 1) run_cycle();
    ld = 1; pin = 500; run_cycle(); ld = 0;
    chk("load_tick_power", int'(io.power), 500);
    ld = 1; pin = 700; run_cycle(); ld = 0;
    on = 1; mi = 2; st = 400;
    run_ticks(650);
    chk("clamp_env", int'(io.env_temp), 300);
    chk("clamp_mode", int'(io.mode), 2);
    run_ticks(20);
    chk("clamp_env_hold", int'(io.env_temp), 300);

    // Hysteresis around set_temp=220.
    do_reset();
    ld = 1; pin = 1023; run_cycle(); ld = 0;
    on = 1; mi = 1; st = 220;
    run_until_env(220, "hyst_down");
    run_ticks(1);
    chk("hyst_off_mode", int'(io.mode), 0);
    chk("hyst_off_env", int'(io.env_temp), 220);
    run_until_env(223, "hyst_band");
    run_ticks(1);
    chk("hyst_band_mode", int'(io.mode), 0);
    run_until_env(226, "hyst_up");
    run_ticks(1);
    chk("hyst_on_mode", int'(io.mode), 1);

    // Randomized segments.
    do_reset();
    for (int s = 0; s < 25; s++) begin
      int len;
      on  = ($urandom_range(0, 3) != 0) ? 1 : 0;
      mi  = $urandom_range(0, 3);
      st  = 150 + $urandom_range(0, 170);
      len = $urandom_range(40, 240);
      for (int c = 0; c < len; c++) begin
        ld  = ($urandom_range(0, 39) == 0) ? 1 : 0;
        pin = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 1023) : $urandom_range(0, 80);
        if ($urandom_range(0, 199) == 0) on = 1 - on;
        run_cycle();
      end
    end
    ld = 0;
    repeat (8) run_cycle();
    chk("sb_drained", sbq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/ac_climate_sim.md
Name: ac_climate_sim

Overview:
- Parametrised successor to the air-conditioner mode/temperature/power simulator.
- Resolves the requested mode (wind/cold/hot) against the room temperature with a hysteresis band.
- Models room temperature and remaining power in 0.1 units, with saturation, ambient drift while idle, and power-exhaustion lockout.
- Sits between the user-input/set-temperature logic and the display/recharge logic. All state runs in the clk domain on a one-cycle tick enable; there is no derived clock.

Parameters:
- CLK_DIV, 10_000_000, clk cycles per tick (10 Hz at 100 MHz).
- TW, 9, temperature width, unsigned, 0.1 degC/LSB.
- PW, 10, power width, unsigned, 0.1 W/LSB.
- ENV_INIT, 240, env_temp reset value.
- POWER_INIT, 100, power reset value.
- AMBIENT, 240, temperature that idle drift moves toward.
- TEMP_MIN, 160, env_temp lower clamp.
- TEMP_MAX, 300, env_temp upper clamp.
- HYST, 5, hysteresis band in LSBs.
- STEP_TICKS, 10, ticks per 1-LSB temperature step in cold/hot.
- WIND_TICKS, 4, ticks per COST_WIND power charge in wind.
- DRIFT_TICKS, 20, ticks per 1-LSB drift step toward AMBIENT.
- COST_ACTIVE, 1, power consumed per tick in cold/hot.
- COST_WIND, 1, power consumed per WIND_TICKS ticks in wind.

Ports:
- clk, input, 1, system clock.
- rst, input, 1, asynchronous active-low reset.
- on_off, input, 1, 1 = unit on.
- mode_in, input, 2, requested mode: 00/11 wind, 01 cold, 10 hot.
- set_temp, input, TW, target temperature.
- power_in, input, PW, recharge value.
- load_power, input, 1, one-cycle recharge strobe.
- mode, output, 2, effective mode: 00 wind, 01 cold, 10 hot.
- env_temp, output, TW, simulated room temperature.
- power, output, PW, remaining power.
- tick, output, 1, one-cycle pulse per tick.
- power_empty, output, 1, high while power==0.
- at_target, output, 1, high while env_temp==set_temp.

Behaviour:
- Reset (rst=0, asynchronous):
  - mode=00, env_temp=ENV_INIT, power=POWER_INIT, tick=0.
  - All internal counters cleared.
  - power_empty and at_target are combinational from the registers, so they are valid immediately.
- Prescaler:
  - Counts 0..CLK_DIV-1 and wraps.
  - tick=1 for exactly the cycle in which the count equals CLK_DIV-1.
  - All updates below happen only on clock edges where tick=1, except load_power.
- Mode resolution at each tick, when on_off=1 and power!=0, evaluated on pre-update env_temp:
  - cold request:
    - env_temp > set_temp+HYST -> cold.
    - env_temp <= set_temp -> wind.
    - otherwise hold cold if currently cold, else wind.
  - hot request: mirror image (env_temp+HYST < set_temp -> hot; env_temp >= set_temp -> wind).
  - 00/11 request -> wind.
  - Comparisons are done at TW+1 bits; no overflow.
- Actions at the same tick, using the newly resolved mode:
  - cold/hot:
    - step_cnt increments; at STEP_TICKS-1 it wraps to 0 and env_temp moves 1 LSB (cold down, hot up), clamped to [TEMP_MIN, TEMP_MAX].
    - Every tick, power -= COST_ACTIVE, saturating at 0.
  - wind:
    - wind_cnt increments; at WIND_TICKS-1 it wraps and power -= COST_WIND, saturating at 0.
    - env_temp drifts as in idle.
  - Any change of effective mode clears step_cnt and wind_cnt in that tick.
- Idle (on_off=0, or power==0):
  - mode forced to 00.
  - No power consumption.
  - drift_cnt counts ticks; at DRIFT_TICKS-1 it wraps and env_temp moves 1 LSB toward AMBIENT, with no change when equal.
- Exhaustion:
  - When a charge drives power to 0 on tick N, mode=00 from tick N+1 onward.
  - Cold/hot stays suppressed until power becomes nonzero.
- Recharge:
  - load_power=1 with on_off=0 -> power<=power_in on that clock edge, independent of tick.
  - Ignored while on_off=1.
  - If it coincides with a tick, the load wins over any power update.
- on_off toggling mid-period does not reset the prescaler; only step/wind/drift counters clear on an on/off transition.

Test Plan:
- Reset with CLK_DIV=4: hold rst=0, then release -> mode=00, env_temp=240, power=100; tick every 4th cycle.
- Cold: on=1, mode_in=01, set_temp=220, 10 ticks -> mode=01, env_temp=239, power=90.
- Hysteresis: cold active, env falls to 220 -> mode=00; env drifts back up to 223, still in band -> mode stays 00; at 226 -> mode=01.
- Wind cost: on=1, mode_in=00, power=100, 8 ticks -> power=98, env_temp unchanged at 240 (equals AMBIENT).
- Exhaustion: power=3, hot, set_temp=280 -> after 3 ticks power=0, power_empty=1, mode=00; load_power while on -> power stays 0.
- Recharge/clamp: on=0, power_in=500, load_power coincident with a tick -> power=500; env_temp=300, hot request at max -> env_temp stays 300.
